frame_burst_writer: RTL
=======================

Name: frame_burst_writer

Overview:
Sits between the pixel CDC FIFO (read side, CLK domain) and the SDRAM controller write port. It pops pixels from the FIFO, packs BurstLengthSDRAM of them into a local burst buffer, then issues one SDRAM write request per full buffer. Write addresses advance linearly through a frame-sized region and wrap at the end of each frame. It reports frame completion to downstream readout logic.

Parameters:
PixelBitWidth, 16, pixel width from FIFO; must equal WordLengthSDRAM
WordLengthSDRAM, 16, SDRAM data word width
BurstLengthSDRAM, 8, words per write burst; power of two
FrameWidth, 640, pixels per line
FrameHeight, 480, lines per frame; FrameWidth*FrameHeight must be a multiple of BurstLengthSDRAM
AddressWidthSDRAM, 24, SDRAM word address width
BaseAddr, 0, first word address of the frame region; burst-aligned

Ports:
CLK  in  1  system clock; single clock domain
RST  in  1  synchronous reset, active-high
i_fifo_data  in  PixelBitWidth  FIFO dout; valid the cycle after o_fifo_rd_en is sampled high
i_fifo_empty  in  1  FIFO empty flag
o_fifo_rd_en  out  1  FIFO pop request
i_frame_sync  in  1  one-cycle pulse at frame start (already synchronised to CLK)
o_enable  out  1  SDRAM write request; held until accepted
o_rw  out  1  SDRAM direction; always 0 (write)
o_addr  out  AddressWidthSDRAM  burst start word address
o_data  out  WordLengthSDRAM  current burst word
i_busy  in  1  SDRAM controller busy; a request is accepted on a cycle with o_enable=1 and i_busy=0
i_word_req  in  1  controller consumes o_data this cycle; advances to the next word
o_frame_done  out  1  one-cycle pulse after the last burst of a frame is transferred
o_burst_count  out  clog2(FrameWidth*FrameHeight/BurstLengthSDRAM)+1  bursts completed in current frame

Behaviour:
- Reset: all outputs are 0; state FILL; issue/capture counters 0; address register = BaseAddr; pending-read flag 0; sync-pending flag 0.
- FSM states: FILL -> REQ -> XFER -> FILL.
- FILL:
  - o_fifo_rd_en = !i_fifo_empty && (issued < BurstLengthSDRAM).
  - A pending flag is registered for every pop. On the following cycle, i_fifo_data is written to buf[captured] and captured is incremented.
  - When captured reaches BurstLengthSDRAM, the next state is REQ. No pop is issued in the transition cycle.
- REQ:
  - o_enable=1, o_rw=0, o_addr=address register.
  - If i_busy=0, the request is accepted. The next state is XFER, and o_enable is 0 from the next cycle.
  - If i_busy=1, all outputs are held stable.
- XFER:
  - o_data = buf[widx] (registered buffer, combinational select).
  - Each cycle with i_word_req=1 increments widx. i_word_req outside XFER is ignored.
  - On consumption of word BurstLengthSDRAM-1:
    - widx, issued and captured clear.
    - o_burst_count increments.
    - Address advances by BurstLengthSDRAM.
    - The next state is FILL.
- Wrap:
  - If the advanced address equals BaseAddr + FrameWidth*FrameHeight, the address reloads BaseAddr and o_burst_count clears.
  - o_frame_done pulses high for exactly one cycle, coincident with the return to FILL.
- Throughput: single buffer; no FIFO pops occur during REQ or XFER. Minimum of BurstLengthSDRAM+1 cycles in FILL per burst.
- i_frame_sync in FILL:
  - Captured, issued and pending all clear. An in-flight FIFO word arriving next cycle is discarded.
  - Address reloads BaseAddr; o_burst_count clears; no o_frame_done pulse.
  - If sync coincides with a pop, that pop's data is discarded.
- i_frame_sync in REQ or XFER: latched into the sync-pending flag. The current burst completes normally at its original address. Then the sync is applied as above (address reload), overriding the normal advance. If the same completion also wraps, o_frame_done still pulses.
- Reset mid-burst: RST has priority over everything. The partial burst is abandoned and o_enable drops the next cycle.
- Arithmetic:
  - Address addition is AddressWidthSDRAM bits wide.
  - The wrap compare uses full-width constants.
  - widx, issued and captured are clog2(BurstLengthSDRAM)+1 bits.

Test Plan:
- FIFO pre-loaded with 0x0001..0x0008, i_busy=0, i_word_req held high in XFER -> 8 pops on consecutive cycles, o_enable for 1 cycle with o_addr=0, o_data sequence 0x0001..0x0008, o_burst_count=1, 9th pop only after return to FILL.
- Same burst with i_busy=1 for 5 cycles -> o_enable, o_addr, o_rw=0 stable for 6 cycles; no FIFO pops during that time; transfer proceeds after release.
- i_fifo_empty toggling every other cycle; i_word_req 1 cycle in 3 -> captured data order preserved, no duplicate or lost pixel across 4 bursts, addresses 0,8,16,24.
- Stream 307200 pixels -> 38400 bursts, o_frame_done one pulse after burst 38400, next burst at o_addr=0, o_burst_count=0 then 1.
- i_frame_sync after 3 captured pixels -> those 3 discarded; next burst contains the following 8 pixels at o_addr=0. Sync during XFER of the burst at address 40 -> burst finishes at 40, the next one at 0.
- RST asserted in XFER at word 4 -> next cycle all outputs 0, state FILL; the following burst starts at BaseAddr.

Source files
------------

// File: rtl/frame_burst_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : frame_burst_writer_if
//  Description : Bundles the FIFO read port and SDRAM write port seen by the
//                frame burst writer. The master modport is the writer itself;
//                the slave modport is the FIFO/SDRAM side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface frame_burst_writer_if #(
    parameter int PIXEL_BIT_WIDTH     = 16,
    parameter int WORD_LENGTH_SDRAM   = 16,
    parameter int ADDRESS_WIDTH_SDRAM = 24,
    parameter int BURST_COUNT_WIDTH   = 17
);
    // FIFO read side
    logic [PIXEL_BIT_WIDTH-1:0]     i_fifo_data;
    logic                           i_fifo_empty;
    logic                           o_fifo_rd_en;
    // Frame timing
    logic                           i_frame_sync;
    logic                           o_frame_done;
    logic [BURST_COUNT_WIDTH-1:0]   o_burst_count;
    // SDRAM controller write port
    logic                           o_enable;
    logic                           o_rw;
    logic [ADDRESS_WIDTH_SDRAM-1:0] o_addr;
    logic [WORD_LENGTH_SDRAM-1:0]   o_data;
    logic                           i_busy;
    logic                           i_word_req;

    modport master (
        input  i_fifo_data, i_fifo_empty, i_frame_sync, i_busy, i_word_req,
        output o_fifo_rd_en, o_enable, o_rw, o_addr, o_data, o_frame_done,
               o_burst_count
    );

    modport slave (
        output i_fifo_data, i_fifo_empty, i_frame_sync, i_busy, i_word_req,
        input  o_fifo_rd_en, o_enable, o_rw, o_addr, o_data, o_frame_done,
               o_burst_count
    );
endinterface
`default_nettype wire

// File: rtl/frame_burst_writer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_burst_writer
//  Description : Pops pixels from the pixel FIFO into a single burst buffer,
//                then issues one SDRAM write burst per full buffer. Addresses
//                advance linearly through a frame region and wrap per frame;
//                frame sync restarts the frame at the base address.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_burst_writer #(
    parameter int PIXEL_BIT_WIDTH     = 16,
    parameter int WORD_LENGTH_SDRAM   = 16,
    parameter int BURST_LENGTH_SDRAM  = 8,
    parameter int FRAME_WIDTH         = 640,
    parameter int FRAME_HEIGHT        = 480,
    parameter int ADDRESS_WIDTH_SDRAM = 24,
    parameter int BASE_ADDR           = 0
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    frame_burst_writer_if.master  bus
);
    localparam int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int FRAME_BURSTS = FRAME_PIXELS / BURST_LENGTH_SDRAM;
    localparam int CW           = $clog2(BURST_LENGTH_SDRAM) + 1;
    localparam int IW           = $clog2(BURST_LENGTH_SDRAM);
    localparam int BCW          = $clog2(FRAME_BURSTS) + 1;
    localparam int AW           = ADDRESS_WIDTH_SDRAM;

    localparam logic [AW-1:0]  C_BASE_ADDR  = AW'(BASE_ADDR);
    localparam logic [AW-1:0]  C_FRAME_END  = AW'(BASE_ADDR + FRAME_PIXELS);
    localparam logic [AW-1:0]  C_BURST_STEP = AW'(BURST_LENGTH_SDRAM);
    localparam logic [CW-1:0]  C_BL_CNT     = CW'(BURST_LENGTH_SDRAM);
    localparam logic [CW-1:0]  C_LAST_IDX   = CW'(BURST_LENGTH_SDRAM - 1);
    localparam logic [CW-1:0]  C_CNT_ONE    = CW'(1);
    localparam logic [BCW-1:0] C_BC_ONE     = BCW'(1);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    state_t               r_state_q,       w_state_d;
    logic [CW-1:0]        r_issued_q,      w_issued_d;
    logic [CW-1:0]        r_captured_q,    w_captured_d;
    logic [CW-1:0]        r_widx_q,        w_widx_d;
    logic                 r_pend_q,        w_pend_d;
    logic                 r_sync_pend_q,   w_sync_pend_d;
    logic [AW-1:0]        r_addr_q,        w_addr_d;
    logic [BCW-1:0]       r_burst_count_q, w_burst_count_d;
    logic                 r_enable_q,      w_enable_d;
    logic                 r_frame_done_q,  w_frame_done_d;

    logic [PIXEL_BIT_WIDTH-1:0] r_buf_q [BURST_LENGTH_SDRAM];

    logic                 w_rd_en;
    logic                 w_buf_we;
    logic [AW-1:0]        w_addr_next;

    // Next-state, counter, address and output-register computation
    always_comb begin
        w_state_d       = r_state_q;
        w_issued_d      = r_issued_q;
        w_captured_d    = r_captured_q;
        w_widx_d        = r_widx_q;
        w_pend_d        = 1'b0;
        w_sync_pend_d   = r_sync_pend_q;
        w_addr_d        = r_addr_q;
        w_burst_count_d = r_burst_count_q;
        w_enable_d      = r_enable_q;
        w_frame_done_d  = 1'b0;
        w_buf_we        = 1'b0;
        w_addr_next     = r_addr_q + C_BURST_STEP;
        // Pops only while filling; reset suppresses them so no pixel is lost
        w_rd_en         = !RST && (r_state_q == S_FILL) && !bus.i_fifo_empty
                          && (r_issued_q < C_BL_CNT);

        case (r_state_q)
            S_FILL: begin
                if (bus.i_frame_sync) begin
                    // Restart the frame: drop partial burst and in-flight word
                    w_issued_d      = '0;
                    w_captured_d    = '0;
                    w_pend_d        = 1'b0;
                    w_sync_pend_d   = 1'b0;
                    w_addr_d        = C_BASE_ADDR;
                    w_burst_count_d = '0;
                end else begin
                    w_pend_d = w_rd_en;
                    if (w_rd_en) begin
                        w_issued_d = r_issued_q + C_CNT_ONE;
                    end
                    if (r_pend_q) begin
                        w_buf_we     = 1'b1;
                        w_captured_d = r_captured_q + C_CNT_ONE;
                    end
                    if (w_captured_d == C_BL_CNT) begin
                        w_state_d  = S_REQ;
                        w_enable_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (bus.i_frame_sync) begin
                    w_sync_pend_d = 1'b1;
                end
                if (!bus.i_busy) begin
                    w_state_d  = S_XFER;
                    w_enable_d = 1'b0;
                end
            end
            S_XFER: begin
                w_sync_pend_d = r_sync_pend_q | bus.i_frame_sync;
                if (bus.i_word_req) begin
                    if (r_widx_q == C_LAST_IDX) begin
                        w_widx_d     = '0;
                        w_issued_d   = '0;
                        w_captured_d = '0;
                        w_state_d    = S_FILL;
                        if (w_addr_next == C_FRAME_END) begin
                            w_addr_d        = C_BASE_ADDR;
                            w_burst_count_d = '0;
                            w_frame_done_d  = 1'b1;
                        end else begin
                            w_addr_d        = w_addr_next;
                            w_burst_count_d = r_burst_count_q + C_BC_ONE;
                        end
                        // A sync seen during this burst overrides the advance
                        if (r_sync_pend_q || bus.i_frame_sync) begin
                            w_addr_d        = C_BASE_ADDR;
                            w_burst_count_d = '0;
                            w_sync_pend_d   = 1'b0;
                        end
                    end else begin
                        w_widx_d = r_widx_q + C_CNT_ONE;
                    end
                end
            end
            default: begin
                w_state_d = S_FILL;
            end
        endcase
    end

    // Control state and registered outputs; reset overrides everything
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q       <= S_FILL;
            r_issued_q      <= '0;
            r_captured_q    <= '0;
            r_widx_q        <= '0;
            r_pend_q        <= 1'b0;
            r_sync_pend_q   <= 1'b0;
            r_addr_q        <= C_BASE_ADDR;
            r_burst_count_q <= '0;
            r_enable_q      <= 1'b0;
            r_frame_done_q  <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_issued_q      <= w_issued_d;
            r_captured_q    <= w_captured_d;
            r_widx_q        <= w_widx_d;
            r_pend_q        <= w_pend_d;
            r_sync_pend_q   <= w_sync_pend_d;
            r_addr_q        <= w_addr_d;
            r_burst_count_q <= w_burst_count_d;
            r_enable_q      <= w_enable_d;
            r_frame_done_q  <= w_frame_done_d;
        end
    end

    // Burst buffer: data storage only, contents are don't-care until filled
    always_ff @(posedge CLK) begin
        if (w_buf_we) begin
            r_buf_q[r_captured_q[IW-1:0]] <= bus.i_fifo_data;
        end
    end

    assign bus.o_fifo_rd_en  = w_rd_en;
    assign bus.o_enable      = r_enable_q;
    assign bus.o_rw          = 1'b0;
    assign bus.o_addr        = r_enable_q ? r_addr_q : '0;
    assign bus.o_data        = (r_state_q == S_XFER) ? r_buf_q[r_widx_q[IW-1:0]] : '0;
    assign bus.o_frame_done  = r_frame_done_q;
    assign bus.o_burst_count = r_burst_count_q;

endmodule
`default_nettype wire
